// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: cwMEM field positions, access size, write-back select,
// FSM states and the MEM/WB pipeline register layout.
package mem_pkg;
  localparam int CW_RD    = 6;
  localparam int CW_WR    = 5;
  localparam int CW_SZ_HI = 4;
  localparam int CW_SZ_LO = 3;
  localparam int CW_UNS   = 2;
  localparam int CW_WB_HI = 1;
  localparam int CW_WB_LO = 0;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} size_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_NPC = 2'b10, WB_IMM = 2'b11} wb_sel_e;
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] alu_res;
    logic [31:0] npc4;
    logic [31:0] imm;
    logic [4:0]  rdest;
    wb_sel_e     wb_sel;
    logic        rf_we;
    logic        mis_trap;
    logic [31:0] mis_addr;
  } memwb_t;

  // The unused SIZE encoding 11 behaves as a word access.
  function automatic size_e size_decode(input logic [1:0] sz);
    case (sz)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// Load data lane select and sign/zero extension for byte, half and word loads.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    data = {{24{b[7] & ~uns}}, b};
      SZ_H:    data = {{16{h[15] & ~uns}}, h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/register_generic.sv
// Enabled pipeline register with asynchronous active-low clear.
module register_generic #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data-memory port, load alignment, stall generation, MEM/WB register.
// Optional MISALIGN_TRAP_EN suppresses misaligned half/word accesses and flags them to write-back.
module mem_stage
  import mem_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pipe_en,
  input  logic [N-1:0] ALUres,
  input  logic [N-1:0] wrData,
  input  logic [N-1:0] ImmOUT,
  input  logic [N-1:0] NPC4_OUT,
  input  logic [4:0]   Rdest,
  input  logic [6:0]   cwMEM,
  input  logic         rf_we_in,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [3:0]   dmem_be,
  output logic [N-1:0] dmem_wdata,
  input  logic         dmem_ack,
  input  logic [N-1:0] dmem_rdata,
  output logic         mem_stall,
  output logic [N-1:0] memData_wb,
  output logic [N-1:0] ALUres_wb,
  output logic [N-1:0] NPC4_wb,
  output logic [N-1:0] Imm_wb,
  output logic [4:0]   Rdest_wb,
  output logic [1:0]   wbSel_wb,
  output logic         rf_we_wb,
  output logic         mis_trap,
  output logic [N-1:0] mis_addr
);
  state_e       state_q, state_d;
  logic         buf_vld_q, buf_vld_d;
  logic [N-1:0] buf_q, buf_d;
  logic         is_mem, mis, acc_pend, req, wb_en;
  logic [1:0]   a_lo;
  size_e        size;
  logic [3:0]   be_pat;
  logic [N-1:0] wdata, ld_data;
  memwb_t       wb_d, wb_q;

  assign a_lo   = ALUres[1:0];
  assign size   = size_decode(cwMEM[CW_SZ_HI:CW_SZ_LO]);
  assign is_mem = cwMEM[CW_RD] | cwMEM[CW_WR];

`ifdef MISALIGN_TRAP_EN
  assign mis = is_mem & (((size == SZ_H) & a_lo[0]) | ((size == SZ_W) & (a_lo != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  // A completed-but-uncaptured access (buf_vld_q) must not be reissued while the pipe is held.
  assign acc_pend   = is_mem & ~mis & ~buf_vld_q;
  assign req        = acc_pend & rst;
  assign dmem_req   = req;
  assign dmem_we    = req & cwMEM[CW_WR];
  assign dmem_be    = req ? be_pat : 4'b0000;
  assign dmem_addr  = {ALUres[N-1:2], 2'b00};
  assign dmem_wdata = wdata;
  assign mem_stall  = req & ~dmem_ack;
  assign wb_en      = pipe_en & ~mem_stall;

  always_comb begin
    case (size)
      SZ_B: begin
        be_pat = 4'b0001 << a_lo;
        wdata  = {4{wrData[7:0]}};
      end
      SZ_H: begin
        be_pat = a_lo[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{wrData[15:0]}};
      end
      default: begin
        be_pat = 4'b1111;
        wdata  = wrData;
      end
    endcase
  end

  load_align u_align (
    .rdata (dmem_rdata),
    .addr  (a_lo),
    .size  (size),
    .uns   (cwMEM[CW_UNS]),
    .data  (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    buf_vld_d = buf_vld_q;
    buf_d     = buf_q;
    case (state_q)
      S_IDLE:  if (req & ~dmem_ack) state_d = S_WAIT;
      S_WAIT:  if (~req | dmem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Ack landed while the pipe is held: park the aligned data until MEM/WB can take it.
    if (req & dmem_ack & ~pipe_en) begin
      buf_vld_d = 1'b1;
      buf_d     = ld_data;
    end else if (wb_en) begin
      buf_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      buf_vld_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      buf_vld_q <= buf_vld_d;
      buf_q     <= buf_d;
    end
  end

  always_comb begin
    wb_d          = '0;
    wb_d.mem_data = buf_vld_q ? buf_q : ld_data;
    wb_d.alu_res  = ALUres;
    wb_d.npc4     = NPC4_OUT;
    wb_d.imm      = ImmOUT;
    wb_d.rdest    = Rdest;
    wb_d.wb_sel   = wb_sel_e'(cwMEM[CW_WB_HI:CW_WB_LO]);
    wb_d.rf_we    = rf_we_in & ~mis;
    wb_d.mis_trap = mis;
    wb_d.mis_addr = mis ? ALUres : '0;
  end

  register_generic #(.W($bits(memwb_t))) u_memwb (
    .clk (clk),
    .rst (rst),
    .en  (wb_en),
    .d   (wb_d),
    .q   (wb_q)
  );

  assign memData_wb = wb_q.mem_data;
  assign ALUres_wb  = wb_q.alu_res;
  assign NPC4_wb    = wb_q.npc4;
  assign Imm_wb     = wb_q.imm;
  assign Rdest_wb   = wb_q.rdest;
  assign wbSel_wb   = wb_q.wb_sel;
  assign rf_we_wb   = wb_q.rf_we;
  assign mis_trap   = wb_q.mis_trap;
  assign mis_addr   = wb_q.mis_addr;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected MEM/WB contents plus per-scenario port checks.
module tb_mem_stage;
  logic        clk = 1'b0, rst = 1'b0, pipe_en = 1'b1;
  logic [31:0] ALUres = '0, wrData = '0, ImmOUT = '0, NPC4_OUT = '0;
  logic [4:0]  Rdest = '0;
  logic [6:0]  cwMEM = '0;
  logic        rf_we_in = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'hDEAD_BEEF;
  logic [3:0]  dmem_be;
  logic [31:0] memData_wb, ALUres_wb, NPC4_wb, Imm_wb, mis_addr;
  logic [4:0]  Rdest_wb;
  logic [1:0]  wbSel_wb;
  logic        rf_we_wb, mis_trap;

  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic [31:0] mem;
    logic        chk_mem;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic        rf_we;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_stage #(.N(32)) dut (
    .clk(clk), .rst(rst), .pipe_en(pipe_en), .ALUres(ALUres), .wrData(wrData), .ImmOUT(ImmOUT),
    .NPC4_OUT(NPC4_OUT), .Rdest(Rdest), .cwMEM(cwMEM), .rf_we_in(rf_we_in), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .memData_wb(memData_wb),
    .ALUres_wb(ALUres_wb), .NPC4_wb(NPC4_wb), .Imm_wb(Imm_wb), .Rdest_wb(Rdest_wb),
    .wbSel_wb(wbSel_wb), .rf_we_wb(rf_we_wb), .mis_trap(mis_trap), .mis_addr(mis_addr)
  );

  function automatic logic [6:0] mk_cw(input logic rd, wr, input logic [1:0] sz, input logic uns,
                                       input logic [1:0] wb);
    return {rd, wr, sz, uns, wb};
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] a,
                                         input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    case (sz)
      2'b00: begin s = rd >> (8 * a); return uns ? (s & 32'hFF) : {{24{s[7]}}, s[7:0]}; end
      2'b01: begin s = a[1] ? (rd >> 16) : rd; return uns ? (s & 32'hFFFF) : {{16{s[15]}}, s[15:0]}; end
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'(1 << a);
      2'b01:   return a[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [1:0] sz);
    case (sz)
      2'b00:   return {w[7:0], w[7:0], w[7:0], w[7:0]};
      2'b01:   return {w[15:0], w[15:0]};
      default: return w;
    endcase
  endfunction

  // Drives one instruction with k wait states on the memory side and records what the port showed.
  task automatic run_access(input logic [31:0] addr, wdat, rdat, input logic [6:0] cw, input int k,
                            input logic [4:0] rd, input logic rfw, output int stall_cyc, output int req_cyc,
                            output logic [3:0] be0, output logic we0, output logic [31:0] wd0, ad0);
    @(negedge clk);
    ALUres = addr; wrData = wdat; cwMEM = cw; Rdest = rd; rf_we_in = rfw;
    ImmOUT = ~addr; NPC4_OUT = addr + 32'd4;
    stall_cyc = 0; req_cyc = 0; be0 = '0; we0 = 1'b0; wd0 = '0; ad0 = '0;
    for (int i = 0; i <= k; i++) begin
      if (i > 0) @(negedge clk);
      dmem_ack   = (i == k);
      dmem_rdata = (i == k) ? rdat : 32'hDEAD_BEEF;
      #1;
      if (i == 0) begin be0 = dmem_be; we0 = dmem_we; wd0 = dmem_wdata; ad0 = dmem_addr; end
      stall_cyc += int'(mem_stall);
      req_cyc   += int'(dmem_req);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_BEEF; cwMEM = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cwMEM = mk_cw(1, 0, 2'b10, 0, 2'b01); ALUres = 32'h104; rf_we_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dmem_req !== 1'b0)   begin n_err++; $display("FAIL rst_req: got %b exp 0", dmem_req); end
    n_cmp++; if (dmem_we !== 1'b0)    begin n_err++; $display("FAIL rst_we: got %b exp 0", dmem_we); end
    n_cmp++; if (dmem_be !== 4'h0)    begin n_err++; $display("FAIL rst_be: got %h exp 0", dmem_be); end
    n_cmp++; if (mem_stall !== 1'b0)  begin n_err++; $display("FAIL rst_stall: got %b exp 0", mem_stall); end
    n_cmp++; if ({memData_wb, ALUres_wb, NPC4_wb, Imm_wb} !== 128'h0)
      begin n_err++; $display("FAIL rst_wb_data: got %h %h %h %h exp 0", memData_wb, ALUres_wb, NPC4_wb, Imm_wb); end
    n_cmp++; if ({Rdest_wb, wbSel_wb, rf_we_wb, mis_trap, mis_addr} !== '0)
      begin n_err++; $display("FAIL rst_wb_ctl: got %h %h %b %b %h exp 0", Rdest_wb, wbSel_wb, rf_we_wb, mis_trap, mis_addr); end
    cwMEM = '0; rf_we_in = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_load_byte();
    int st, rq; logic [3:0] be; logic we; logic [31:0] wd, ad; exp_t e;
    sb.push_back('{m_load(32'h80FF_1234, 2'd3, 2'b00, 1'b0), 1'b1, 32'h103, 5'd3, 2'b01, 1'b1});
    run_access(32'h103, 32'h0, 32'h80FF_1234, mk_cw(1, 0, 2'b00, 0, 2'b01), 0, 5'd3, 1'b1, st, rq, be, we, wd, ad);
    e = sb.pop_front();
    n_cmp++; if (be !== 4'b1000)       begin n_err++; $display("FAIL lb_be: got %b exp 1000", be); end
    n_cmp++; if (st !== 0)             begin n_err++; $display("FAIL lb_stall: got %0d exp 0", st); end
    n_cmp++; if (ad !== 32'h100)       begin n_err++; $display("FAIL lb_addr: got %h exp 100", ad); end
    n_cmp++; if (memData_wb !== e.mem) begin n_err++; $display("FAIL lb_data: got %h exp %h", memData_wb, e.mem); end
    n_cmp++; if (memData_wb !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_const: got %h exp ffffff80", memData_wb); end
    n_cmp++; if ({ALUres_wb, Rdest_wb, wbSel_wb, rf_we_wb} !== {e.alu, e.rd, e.wb, e.rf_we})
      begin n_err++; $display("FAIL lb_ctl: got %h %h %h %b exp %h %h %h %b", ALUres_wb, Rdest_wb, wbSel_wb, rf_we_wb, e.alu, e.rd, e.wb, e.rf_we); end
    n_cmp++; if ({NPC4_wb, Imm_wb} !== {32'h107, ~32'h103})
      begin n_err++; $display("FAIL lb_pass: got %h %h exp 00000107 fffffefc", NPC4_wb, Imm_wb); end
  endtask

  task automatic test_load_half_wait();
    int st, rq; logic [3:0] be; logic we; logic [31:0] wd, ad; exp_t e;
    sb.push_back('{32'h0000_BEEF, 1'b1, 32'h102, 5'd7, 2'b01, 1'b1});
    run_access(32'h102, 32'h0, 32'hBEEF_0000, mk_cw(1, 0, 2'b01, 1, 2'b01), 2, 5'd7, 1'b1, st, rq, be, we, wd, ad);
    e = sb.pop_front();
    n_cmp++; if (be !== 4'b1100)       begin n_err++; $display("FAIL lh_be: got %b exp 1100", be); end
    n_cmp++; if (st !== 2)             begin n_err++; $display("FAIL lh_stall: got %0d exp 2", st); end
    n_cmp++; if (rq !== 3)             begin n_err++; $display("FAIL lh_req_held: got %0d exp 3", rq); end
    n_cmp++; if (memData_wb !== e.mem) begin n_err++; $display("FAIL lh_data: got %h exp %h", memData_wb, e.mem); end
  endtask

  task automatic test_store_byte();
    int st, rq; logic [3:0] be; logic we; logic [31:0] wd, ad; exp_t e;
    sb.push_back('{32'h0, 1'b0, 32'h201, 5'd0, 2'b00, 1'b0});
    run_access(32'h201, 32'h0000_00A5, 32'h0, mk_cw(0, 1, 2'b00, 0, 2'b00), 1, 5'd0, 1'b0, st, rq, be, we, wd, ad);
    e = sb.pop_front();
    n_cmp++; if (wd !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL sb_wdata: got %h exp a5a5a5a5", wd); end
    n_cmp++; if (be !== 4'b0010)       begin n_err++; $display("FAIL sb_be: got %b exp 0010", be); end
    n_cmp++; if (we !== 1'b1)          begin n_err++; $display("FAIL sb_we: got %b exp 1", we); end
    n_cmp++; if (st !== 1)             begin n_err++; $display("FAIL sb_stall: got %0d exp 1", st); end
    n_cmp++; if ({ALUres_wb, rf_we_wb} !== {e.alu, e.rf_we})
      begin n_err++; $display("FAIL sb_wb: got %h %b exp %h %b", ALUres_wb, rf_we_wb, e.alu, e.rf_we); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] t_addr[6] = '{32'h400, 32'h406, 32'h409, 32'h40C, 32'h410, 32'h412};
    logic [31:0] t_rd[6]   = '{32'hCAFE_BABE, 32'h8001_7FFF, 32'h1122_F344, 32'h0BAD_F00D, 32'h0000_9ABC, 32'h0};
    logic [6:0]  t_cw[6];
    int          t_k[6]    = '{0, 1, 0, 2, 0, 1};
    int st, rq; logic [3:0] be; logic we; logic [31:0] wd, ad; exp_t e; logic [1:0] sz;
    t_cw = '{mk_cw(1, 0, 2'b10, 0, 2'b01), mk_cw(1, 0, 2'b01, 0, 2'b01), mk_cw(1, 0, 2'b00, 1, 2'b01),
             mk_cw(1, 0, 2'b11, 0, 2'b01), mk_cw(1, 0, 2'b01, 0, 2'b01), mk_cw(1, 1, 2'b01, 0, 2'b10)};
    for (int i = 0; i < 6; i++) begin
      sz = t_cw[i][4:3];
      sb.push_back('{m_load(t_rd[i], t_addr[i][1:0], sz, t_cw[i][2]), !t_cw[i][5], t_addr[i], 5'(i + 10),
                     t_cw[i][1:0], 1'b1});
      run_access(t_addr[i], 32'h1234_ABCD, t_rd[i], t_cw[i], t_k[i], 5'(i + 10), 1'b1, st, rq, be, we, wd, ad);
      e = sb.pop_front();
      n_cmp++; if (be !== m_be(t_addr[i][1:0], sz))
        begin n_err++; $display("FAIL b2b_be[%0d]: got %b exp %b", i, be, m_be(t_addr[i][1:0], sz)); end
      n_cmp++; if (we !== t_cw[i][5]) begin n_err++; $display("FAIL b2b_we[%0d]: got %b exp %b", i, we, t_cw[i][5]); end
      n_cmp++; if (st !== t_k[i]) begin n_err++; $display("FAIL b2b_stall[%0d]: got %0d exp %0d", i, st, t_k[i]); end
      if (e.chk_mem) begin
        n_cmp++; if (memData_wb !== e.mem) begin n_err++; $display("FAIL b2b_data[%0d]: got %h exp %h", i, memData_wb, e.mem); end
      end else begin
        n_cmp++; if (wd !== m_wdata(32'h1234_ABCD, sz))
          begin n_err++; $display("FAIL b2b_wdata[%0d]: got %h exp %h", i, wd, m_wdata(32'h1234_ABCD, sz)); end
      end
      n_cmp++; if ({ALUres_wb, Rdest_wb, wbSel_wb} !== {e.alu, e.rd, e.wb})
        begin n_err++; $display("FAIL b2b_ctl[%0d]: got %h %h %h exp %h %h %h", i, ALUres_wb, Rdest_wb, wbSel_wb, e.alu, e.rd, e.wb); end
    end
  endtask

  task automatic test_nonmem();
    int st, rq; logic [3:0] be; logic we; logic [31:0] wd, ad; exp_t e;
    sb.push_back('{32'h0, 1'b0, 32'hDEAD_0010, 5'd5, 2'b11, 1'b1});
    run_access(32'hDEAD_0010, 32'h0, 32'h0, mk_cw(0, 0, 2'b10, 0, 2'b11), 0, 5'd5, 1'b1, st, rq, be, we, wd, ad);
    e = sb.pop_front();
    n_cmp++; if (rq !== 0) begin n_err++; $display("FAIL nm_req: got %0d exp 0", rq); end
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL nm_stall: got %0d exp 0", st); end
    n_cmp++; if ({ALUres_wb, Rdest_wb, wbSel_wb, rf_we_wb} !== {e.alu, e.rd, e.wb, e.rf_we})
      begin n_err++; $display("FAIL nm_wb: got %h %h %h %b exp %h %h %h %b", ALUres_wb, Rdest_wb, wbSel_wb, rf_we_wb, e.alu, e.rd, e.wb, e.rf_we); end
  endtask

  task automatic test_pipe_hold();
    int rq; exp_t e;
    sb.push_back('{32'h1234_5678, 1'b1, 32'h300, 5'd9, 2'b01, 1'b1});
    @(negedge clk);
    pipe_en = 1'b0; ALUres = 32'h300; cwMEM = mk_cw(1, 0, 2'b10, 0, 2'b01); Rdest = 5'd9; rf_we_in = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    #1 rq = int'(dmem_req);
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL pe_stall: got %b exp 0", mem_stall); end
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
    #1 rq += int'(dmem_req);
    n_cmp++; if (ALUres_wb !== 32'hDEAD_0010) begin n_err++; $display("FAIL pe_frozen: got %h exp dead0010", ALUres_wb); end
    @(negedge clk);
    #1 rq += int'(dmem_req);
    pipe_en = 1'b1;
    #1 rq += int'(dmem_req);
    @(posedge clk); #1;
    cwMEM = '0;
    e = sb.pop_front();
    n_cmp++; if (rq !== 1) begin n_err++; $display("FAIL pe_req_once: got %0d exp 1", rq); end
    n_cmp++; if (memData_wb !== e.mem) begin n_err++; $display("FAIL pe_data: got %h exp %h", memData_wb, e.mem); end
    n_cmp++; if (ALUres_wb !== e.alu) begin n_err++; $display("FAIL pe_alu: got %h exp %h", ALUres_wb, e.alu); end
  endtask

  task automatic test_misalign();
    int st, rq; logic [3:0] be; logic we; logic [31:0] wd, ad;
    run_access(32'h102, 32'h0, 32'h5566_7788, mk_cw(1, 0, 2'b10, 0, 2'b01), 0, 5'd4, 1'b1, st, rq, be, we, wd, ad);
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if (rq !== 0) begin n_err++; $display("FAIL mis_req: got %0d exp 0", rq); end
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL mis_stall: got %0d exp 0", st); end
    n_cmp++; if (mis_trap !== 1'b1) begin n_err++; $display("FAIL mis_trap: got %b exp 1", mis_trap); end
    n_cmp++; if (mis_addr !== 32'h102) begin n_err++; $display("FAIL mis_addr: got %h exp 102", mis_addr); end
    n_cmp++; if (rf_we_wb !== 1'b0) begin n_err++; $display("FAIL mis_rfwe: got %b exp 0", rf_we_wb); end
    run_access(32'h104, 32'h0, 32'h0, mk_cw(0, 0, 2'b00, 0, 2'b00), 0, 5'd4, 1'b1, st, rq, be, we, wd, ad);
    n_cmp++; if ({mis_trap, rf_we_wb} !== 2'b01) begin n_err++; $display("FAIL mis_clear: got %b%b exp 01", mis_trap, rf_we_wb); end
`else
    n_cmp++; if (be !== 4'hF) begin n_err++; $display("FAIL mis_be: got %b exp 1111", be); end
    n_cmp++; if (ad !== 32'h100) begin n_err++; $display("FAIL mis_addrw: got %h exp 100", ad); end
    n_cmp++; if (memData_wb !== 32'h5566_7788) begin n_err++; $display("FAIL mis_data: got %h exp 55667788", memData_wb); end
    n_cmp++; if ({mis_trap, mis_addr, rf_we_wb} !== {1'b0, 32'h0, 1'b1})
      begin n_err++; $display("FAIL mis_off: got %b %h %b exp 0 0 1", mis_trap, mis_addr, rf_we_wb); end
`endif
  endtask

  task automatic test_async_reset();
    int st, rq; logic [3:0] be; logic we; logic [31:0] wd, ad;
    @(negedge clk);
    ALUres = 32'h500; cwMEM = mk_cw(1, 0, 2'b10, 0, 2'b01); Rdest = 5'd2; rf_we_in = 1'b1; dmem_ack = 1'b0;
    @(posedge clk); #2;
    n_cmp++; if ({dmem_req, mem_stall} !== 2'b11) begin n_err++; $display("FAIL ar_wait: got %b%b exp 11", dmem_req, mem_stall); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({dmem_req, mem_stall} !== 2'b00) begin n_err++; $display("FAIL ar_drop: got %b%b exp 00", dmem_req, mem_stall); end
    @(negedge clk); cwMEM = '0; rf_we_in = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    n_cmp++; if ({memData_wb, ALUres_wb, NPC4_wb, Imm_wb} !== 128'h0)
      begin n_err++; $display("FAIL ar_wb_data: got %h %h %h %h exp 0", memData_wb, ALUres_wb, NPC4_wb, Imm_wb); end
    n_cmp++; if ({Rdest_wb, wbSel_wb, rf_we_wb, mis_trap, mis_addr, dmem_req, dmem_we, dmem_be} !== '0)
      begin n_err++; $display("FAIL ar_ctl: got %h %h %b %b %h %b %b %h exp 0", Rdest_wb, wbSel_wb, rf_we_wb, mis_trap, mis_addr, dmem_req, dmem_we, dmem_be); end
    sb.push_back('{32'h1357_9BDF, 1'b1, 32'h504, 5'd2, 2'b01, 1'b1});
    run_access(32'h504, 32'h0, 32'h1357_9BDF, mk_cw(1, 0, 2'b10, 0, 2'b01), 0, 5'd2, 1'b1, st, rq, be, we, wd, ad);
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL ar_recover_stall: got %0d exp 0", st); end
    n_cmp++; if (memData_wb !== sb[0].mem) begin n_err++; $display("FAIL ar_recover_data: got %h exp %h", memData_wb, sb[0].mem); end
    void'(sb.pop_front());
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_half_wait();
    test_store_byte();
    test_back_to_back();
    test_nonmem();
    test_pipe_hold();
    test_misalign();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
